// File: rtl/pc_stack_sequencer.sv
// Return-PC stack for loop entry/exit, kept in data memory as little-endian byte pairs.
// Optional `PC_STACK_PEEK_EN` adds peek_req: replay the top entry without popping it.
module pc_stack_sequencer #(
  parameter logic [15:0] STACK_BASE = 16'hFF00,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned DW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_req,
  input  logic          pop_req,
`ifdef PC_STACK_PEEK_EN
  input  logic          peek_req,
`endif
  input  logic [15:0]   pc_i,
  input  logic          dp_mem_req,
  output logic          dp_mem_grant,
  output logic [15:0]   mem_addr,
  output logic          mem_active,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [15:0]   pc_loaded,
  output logic          pc_src,
  output logic          bubble,
  output logic [DW-1:0] depth,
  output logic          overflow,
  output logic          underflow
);

  typedef enum logic [2:0] {
    StIdle, StPushLo, StPushHi, StPopHi, StPopLo, StPopCap, StLoad
  } state_e;

  localparam logic [DW-1:0] DepthFull = DW'(DEPTH);

  state_e        r_state;
  logic [15:0]   r_pc;
  logic [DW-1:0] r_depth;
  logic [15:0]   r_pc_loaded;
  logic [15:0]   r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic          r_mem_we;
  logic          r_mem_active;
  logic          r_pc_src;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_idle;
  logic          w_empty;
  logic          w_full;
  logic          w_peek_req;
  logic          w_keep;
  logic          w_pop_acc;
  logic          w_peek_acc;
  logic          w_push_acc;
  logic          w_any_acc;
  logic [15:0]   w_off;
  logic [15:0]   w_push_addr;
  logic [15:0]   w_top_hi_addr;

`ifdef PC_STACK_PEEK_EN
  logic r_keep;
  assign w_peek_req = peek_req;
  assign w_keep     = r_keep;
`else
  assign w_peek_req = 1'b0;
  assign w_keep     = 1'b0;
`endif

  assign w_idle  = (r_state == StIdle);
  assign w_empty = (r_depth == '0);
  assign w_full  = (r_depth >= DepthFull);

  // Priority pop > peek > push; losers are dropped without flagging.
  assign w_pop_acc  = w_idle & pop_req & ~w_empty;
  assign w_peek_acc = w_idle & ~pop_req & w_peek_req & ~w_empty;
  assign w_push_acc = w_idle & ~pop_req & ~w_peek_req & push_req & ~w_full;
  assign w_any_acc  = w_pop_acc | w_peek_acc | w_push_acc;

  assign w_off         = 16'({r_depth, 1'b0});
  assign w_push_addr   = STACK_BASE + w_off;
  assign w_top_hi_addr = STACK_BASE + w_off - 16'd1;

  assign bubble       = ~w_idle | w_any_acc;
  assign dp_mem_grant = dp_mem_req & w_idle & ~w_any_acc;
  assign mem_addr     = r_mem_addr;
  assign mem_active   = r_mem_active;
  assign mem_we       = r_mem_we;
  assign mem_wdata    = r_mem_wdata;
  assign pc_loaded    = r_pc_loaded;
  assign pc_src       = r_pc_src;
  assign depth        = r_depth;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_pc         <= '0;
      r_depth      <= '0;
      r_pc_loaded  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_mem_active <= 1'b0;
      r_pc_src     <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
`ifdef PC_STACK_PEEK_EN
      r_keep       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pop_acc || w_peek_acc) begin
            r_state      <= StPopHi;
            r_mem_addr   <= w_top_hi_addr;
            r_mem_we     <= 1'b0;
            r_mem_active <= 1'b1;
`ifdef PC_STACK_PEEK_EN
            r_keep       <= w_peek_acc;
`endif
          end else if (w_push_acc) begin
            r_state      <= StPushLo;
            r_pc         <= pc_i;
            r_mem_addr   <= w_push_addr;
            r_mem_wdata  <= pc_i[7:0];
            r_mem_we     <= 1'b1;
            r_mem_active <= 1'b1;
          end
          if (w_idle && (pop_req || w_peek_req) && w_empty) begin
            r_underflow <= 1'b1;
          end
          if (w_idle && push_req && !pop_req && !w_peek_req && w_full) begin
            r_overflow <= 1'b1;
          end
        end
        StPushLo: begin
          r_state     <= StPushHi;
          r_mem_addr  <= r_mem_addr + 16'd1;
          r_mem_wdata <= r_pc[15:8];
        end
        StPushHi: begin
          r_state      <= StIdle;
          r_mem_we     <= 1'b0;
          r_mem_active <= 1'b0;
          r_depth      <= r_depth + DW'(1);
        end
        StPopHi: begin
          r_state    <= StPopLo;
          r_mem_addr <= r_mem_addr - 16'd1;
        end
        StPopLo: begin
          // Synchronous read: the high byte addressed in StPopHi arrives now.
          r_state            <= StPopCap;
          r_pc_loaded[15:8]  <= mem_rdata;
          r_mem_active       <= 1'b0;
        end
        StPopCap: begin
          r_state          <= StLoad;
          r_pc_loaded[7:0] <= mem_rdata;
          r_pc_src         <= 1'b1;
        end
        StLoad: begin
          r_state  <= StIdle;
          r_pc_src <= 1'b0;
          if (!w_keep) begin
            r_depth <= r_depth - DW'(1);
          end
        end
        default: begin
          r_state      <= StIdle;
          r_mem_we     <= 1'b0;
          r_mem_active <= 1'b0;
          r_pc_src     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Directed bench for pc_stack_sequencer with a small synchronous-read stack memory model.
// Define PC_STACK_PEEK_EN for both RTL and bench to exercise peek_req.
module tb_pc_stack_sequencer;

  logic        clk;
  logic        rst_n;
  logic        push_req;
  logic        pop_req;
`ifdef PC_STACK_PEEK_EN
  logic        peek_req;
`endif
  logic [15:0] pc_i;
  logic        dp_mem_req;
  logic        dp_mem_grant;
  logic [15:0] mem_addr;
  logic        mem_active;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] pc_loaded;
  logic        pc_src;
  logic        bubble;
  logic [5:0]  depth;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_errors = 0;
  int m_depth  = 0;
  int wr_cnt   = 0;
  logic [7:0] mem [0:255];

  pc_stack_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_req     (push_req),
    .pop_req      (pop_req),
`ifdef PC_STACK_PEEK_EN
    .peek_req     (peek_req),
`endif
    .pc_i         (pc_i),
    .dp_mem_req   (dp_mem_req),
    .dp_mem_grant (dp_mem_grant),
    .mem_addr     (mem_addr),
    .mem_active   (mem_active),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .pc_loaded    (pc_loaded),
    .pc_src       (pc_src),
    .bubble       (bubble),
    .depth        (depth),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack page model: only FFxx is backed; reads return data one cycle after the address.
  always @(posedge clk) begin
    if (mem_active && mem_we && mem_addr[15:8] == 8'hFF) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_depth = 0;
    @(negedge clk);
  endtask

  task automatic do_push(input logic [15:0] pc);
    logic [15:0] a;
    a = 16'hFF00 + 16'(2 * m_depth);
    @(negedge clk);
    push_req = 1'b1;
    pc_i = pc;
    #1;
    check_eq("push_req_bubble", bubble, 1);
    check_eq("push_req_grant", dp_mem_grant, 0);
    @(negedge clk);
    push_req = 1'b0;
    check_eq("push_lo_we", mem_we, 1);
    check_eq("push_lo_active", mem_active, 1);
    check_eq("push_lo_addr", mem_addr, a);
    check_eq("push_lo_wdata", mem_wdata, pc[7:0]);
    check_eq("push_lo_grant", dp_mem_grant, 0);
    @(negedge clk);
    check_eq("push_hi_we", mem_we, 1);
    check_eq("push_hi_addr", mem_addr, a + 16'd1);
    check_eq("push_hi_wdata", mem_wdata, pc[15:8]);
    check_eq("push_hi_bubble", bubble, 1);
    check_eq("push_hi_grant", dp_mem_grant, 0);
    @(negedge clk);
    m_depth++;
    check_eq("push_done_depth", depth, m_depth);
    check_eq("push_done_bubble", bubble, 0);
    check_eq("push_done_we", mem_we, 0);
    check_eq("push_done_grant", dp_mem_grant, dp_mem_req);
    check_eq("push_mem_lo", mem[a[7:0]], pc[7:0]);
    check_eq("push_mem_hi", mem[a[7:0] + 8'd1], pc[15:8]);
  endtask

  // keep=1 issues a peek instead of a pop; with_push also raises push_req, which must lose.
  task automatic do_pop(input logic [15:0] exp, input logic with_push, input logic keep);
    logic [15:0] a;
    int wr0;
    a = 16'hFF00 + 16'(2 * (m_depth - 1));
    @(negedge clk);
    if (keep) begin
`ifdef PC_STACK_PEEK_EN
      peek_req = 1'b1;
`endif
    end else begin
      pop_req = 1'b1;
    end
    push_req = with_push;
    pc_i = 16'h1111;
    #1;
    check_eq("pop_req_bubble", bubble, 1);
    wr0 = wr_cnt;
    @(negedge clk);
    pop_req = 1'b0;
    push_req = 1'b0;
`ifdef PC_STACK_PEEK_EN
    peek_req = 1'b0;
`endif
    check_eq("pop_hi_active", mem_active, 1);
    check_eq("pop_hi_we", mem_we, 0);
    check_eq("pop_hi_addr", mem_addr, a + 16'd1);
    check_eq("pop_hi_pc_src", pc_src, 0);
    @(negedge clk);
    check_eq("pop_lo_active", mem_active, 1);
    check_eq("pop_lo_addr", mem_addr, a);
    @(negedge clk);
    check_eq("pop_cap_active", mem_active, 0);
    check_eq("pop_cap_pc_src", pc_src, 0);
    @(negedge clk);
    check_eq("load_pc_src", pc_src, 1);
    check_eq("load_pc_loaded", pc_loaded, exp);
    check_eq("load_bubble", bubble, 1);
    @(negedge clk);
    if (!keep) m_depth--;
    check_eq("pop_done_pc_src", pc_src, 0);
    check_eq("pop_done_bubble", bubble, 0);
    check_eq("pop_done_depth", depth, m_depth);
    check_eq("pop_no_write", wr_cnt, wr0);
  endtask

  initial begin
    int wr0;
    int seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    push_req   = 1'b0;
    pop_req    = 1'b0;
`ifdef PC_STACK_PEEK_EN
    peek_req   = 1'b0;
`endif
    pc_i       = 16'h0000;
    dp_mem_req = 1'b0;
    do_reset();

    check_eq("rst_depth", depth, 0);
    check_eq("rst_pc_loaded", pc_loaded, 0);
    check_eq("rst_pc_src", pc_src, 0);
    check_eq("rst_bubble", bubble, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_active", mem_active, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_underflow", underflow, 0);

    do_push(16'h1234);
    do_pop(16'h1234, 1'b0, 1'b0);

    do_push(16'h0010);
    do_push(16'h0020);
    do_push(16'h0030);
    check_eq("lifo_mem_ff00", mem[8'h00], 8'h10);
    check_eq("lifo_mem_ff02", mem[8'h02], 8'h20);
    check_eq("lifo_mem_ff04", mem[8'h04], 8'h30);
    do_pop(16'h0030, 1'b0, 1'b0);
    do_pop(16'h0020, 1'b0, 1'b0);
    do_pop(16'h0010, 1'b0, 1'b0);

    dp_mem_req = 1'b1;
    @(negedge clk);
    check_eq("idle_grant", dp_mem_grant, 1);
    do_push(16'h4444);
    dp_mem_req = 1'b0;
    do_pop(16'h4444, 1'b0, 1'b0);

    do_push(16'hABCD);
    do_pop(16'hABCD, 1'b1, 1'b0);
    check_eq("simul_overflow", overflow, 0);

`ifdef PC_STACK_PEEK_EN
    do_push(16'h0111);
    do_push(16'h0555);
    do_pop(16'h0555, 1'b0, 1'b1);
    check_eq("peek_depth", depth, 2);
    do_pop(16'h0555, 1'b0, 1'b0);
    do_pop(16'h0111, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 32; i++) do_push(16'h0100 + 16'(i));
    @(negedge clk);
    push_req = 1'b1;
    pc_i = 16'hDEAD;
    #1;
    check_eq("ovf_req_bubble", bubble, 0);
    wr0 = wr_cnt;
    @(negedge clk);
    push_req = 1'b0;
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_we", mem_we, 0);
    @(negedge clk);
    check_eq("ovf_we_later", mem_we, 0);
    check_eq("ovf_depth", depth, 32);
    check_eq("ovf_no_write", wr_cnt, wr0);
    do_pop(16'h011F, 1'b0, 1'b0);
    check_eq("ovf_sticky", overflow, 1);

    do_reset();
    check_eq("rst2_overflow", overflow, 0);
    @(negedge clk);
    pop_req = 1'b1;
    #1;
    check_eq("udf_req_bubble", bubble, 0);
    seen = 0;
    @(negedge clk);
    pop_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (pc_src) seen++;
      @(negedge clk);
    end
    check_eq("udf_flag", underflow, 1);
    check_eq("udf_pc_src_seen", seen, 0);
    check_eq("udf_depth", depth, 0);

    do_reset();
    @(negedge clk);
    push_req = 1'b1;
    pc_i = 16'hBEEF;
    @(negedge clk);
    push_req = 1'b0;
    @(negedge clk);
    check_eq("rstmid_we_before", mem_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_we_async", mem_we, 0);
    check_eq("rstmid_active_async", mem_active, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstmid_depth", depth, 0);
    check_eq("rstmid_bubble", bubble, 0);
    check_eq("rstmid_pc_src", pc_src, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
